// File: rtl/tail_light_ctrl.sv
// Sequential tail-light controller: three-lamp turn sequencer per side, hazard, brake and PWM-dimmed running lights.
// Latency: la/ra are registered, one cycle after the state/pwm/brake/on they reflect; seq_state is the state register itself.
// Backpressure: none; requests are level inputs sampled on prescaler ticks, brake/on every cycle.
//
// Ports:
//   fst_clk    - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   on         - running lights; otherwise-dark lamps glow at DIM_LEVEL/8 duty
//   left       - left turn request (sampled on tick only)
//   right      - right turn request (sampled on tick only)
//   hazard     - hazard request (sampled on tick only)
//   brake      - brake; lamps on non-sequencing sides go full
//   la[2:0]    - left lamps, bit0 inner (LA) .. bit2 outer (LC)
//   ra[2:0]    - right lamps, same bit order
//   seq_state  - current FSM state encoding
module tail_light_ctrl #(
  parameter int DIV_EXP   = 20,
  parameter int DIM_LEVEL = 2
) (
  input  logic       fst_clk,
  input  logic       rst_n,
  input  logic       on,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic [2:0] la,
  output logic [2:0] ra,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_EXP-1:0]   presc_q, presc_d;
  logic [2:0]           pwm_cnt_q, pwm_cnt_d;
  logic [2:0]           la_q, la_d;
  logic [2:0]           ra_q, ra_d;
  logic                 tick;
  logic                 dim;

  // Step timing: one tick per 2^DIV_EXP cycles, on the all-ones count.
  assign presc_d = presc_q + DIV_EXP'(1);
  assign tick    = &presc_q;

  // Dim PWM: 4-bit compare so DIM_LEVEL=8 yields a constant 1.
  assign pwm_cnt_d = pwm_cnt_q + 3'd1;
  assign dim       = ({1'b0, pwm_cnt_q} < 4'(DIM_LEVEL));

  // Next-state: requests only matter in IDLE on a tick; running
  // sequences complete regardless of what the request inputs do.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (hazard || (left && right)) state_d = HAZ;
          else if (left)                 state_d = L1;
          else if (right)                state_d = R1;
          else                           state_d = IDLE;
        end
        L1:      state_d = L2;
        L2:      state_d = L3;
        L3:      state_d = IDLE;
        R1:      state_d = R2;
        R2:      state_d = R3;
        R3:      state_d = IDLE;
        HAZ:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Lamp levels from the current state register (not state_d), so the
  // registered lamps lag the state by exactly one cycle.
  logic [2:0] act_l, act_r;
  logic       seq_l, seq_r;

  always_comb begin
    act_l = 3'b000;
    act_r = 3'b000;
    seq_l = 1'b0;
    seq_r = 1'b0;
    unique case (state_q)
      L1:  begin act_l = 3'b001; seq_l = 1'b1; end
      L2:  begin act_l = 3'b011; seq_l = 1'b1; end
      L3:  begin act_l = 3'b111; seq_l = 1'b1; end
      R1:  begin act_r = 3'b001; seq_r = 1'b1; end
      R2:  begin act_r = 3'b011; seq_r = 1'b1; end
      R3:  begin act_r = 3'b111; seq_r = 1'b1; end
      HAZ: begin
        act_l = 3'b111;
        act_r = 3'b111;
        seq_l = 1'b1;
        seq_r = 1'b1;
      end
      default: begin
        act_l = 3'b000;
        act_r = 3'b000;
      end
    endcase
  end

  // Brake only lights a side that is not sequencing; a sequencing side's
  // inactive lamps keep the turn pattern readable and fall back to dim.
  always_comb begin
    la_d = act_l
         | ((!seq_l && brake) ? 3'b111 : 3'b000)
         | ((on && dim)       ? 3'b111 : 3'b000);
    ra_d = act_r
         | ((!seq_r && brake) ? 3'b111 : 3'b000)
         | ((on && dim)       ? 3'b111 : 3'b000);
  end

  always_ff @(posedge fst_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      pwm_cnt_q <= 3'd0;
      la_q      <= 3'b000;
      ra_q      <= 3'b000;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      la_q      <= la_d;
      ra_q      <= ra_d;
    end
  end

  assign la        = la_q;
  assign ra        = ra_q;
  assign seq_state = state_q;

endmodule
